// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI byte-stream parser and its event FIFO.
package midi_pkg;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHPRESS  = 4'hD;

   localparam logic [7:0] SYSEX  = 8'hF0;
   localparam logic [7:0] EOX    = 8'hF7;
   localparam logic [7:0] RT_MIN = 8'hF8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_D1   = 2'd1,
      ST_D2   = 2'd2,
      ST_SKIP = 2'd3
   } parse_state_t;

   typedef struct packed {
      logic       on;
      logic [6:0] note;
      logic [6:0] velocity;
      logic [3:0] channel;
   } midi_event_t;

   // Messages carrying a single data byte complete in D1.
   function automatic logic is_one_data(input logic [3:0] nibble);
      return (nibble == PROG) || (nibble == CHPRESS);
   endfunction

endpackage

// File: rtl/midi_event_fifo.sv
// Show-ahead FIFO of note events; the head is a register that holds its last
// value while the FIFO is empty.
module midi_event_fifo
   import midi_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        nreset,
   input  logic        push,
   input  midi_event_t wdata,
   input  logic        pop,
   output midi_event_t rdata,
   output logic        empty,
   output logic        full
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   midi_event_t   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic [AW-1:0] rd_next;
   logic          do_push;
   logic          do_pop;

   assign empty      = (count == '0);
   assign full       = (count == CNT_FULL);
   assign do_pop     = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push    = push && (!full || do_pop);
   assign rd_next    = do_pop ? rd_ptr + 1'b1 : rd_ptr;
   assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

   // NOTE: the storage array has no reset; the head register and count are
   // reset, so stale entries are never observable.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         rdata  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_next;
         count  <= count_next;
         // The new head is either already in memory or being written right now.
         if (count_next != '0)
            rdata <= (do_push && (wr_ptr == rd_next)) ? wdata : mem[rd_next];
      end
   end

endmodule

// File: rtl/midi_event_parser.sv
// Status-aware MIDI parser: running status, real-time passthrough, SysEx
// skipping and note-on/off extraction into a valid/ready event FIFO.
module midi_event_parser
   import midi_pkg::*;
#(
   parameter int unsigned CHANNEL    = 0,
   parameter bit          OMNI       = 1'b1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic       ev_on,
   output logic [6:0] ev_note,
   output logic [6:0] ev_velocity,
   output logic [3:0] ev_channel,
   output logic       overflow,
   input  logic       overflow_clr
);

   localparam logic [3:0] CH = 4'(CHANNEL);

   parse_state_t state;
   logic [7:0]   rs;
   logic         rs_valid;
   logic [6:0]   d1;

   logic         is_status;
   logic         is_rt;
   logic         emit;
   logic         fifo_full;
   logic         fifo_empty;
   logic         drop;
   midi_event_t  ev_new;
   midi_event_t  head;

   assign is_rt     = (in_data >= RT_MIN);
   assign is_status = in_data[7];

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      emit   = 1'b0;
      ev_new = '0;
      if (in_valid && !is_status && (state == ST_D2) && rs_valid &&
          ((rs[7:4] == NOTE_ON) || (rs[7:4] == NOTE_OFF)) &&
          (OMNI || (rs[3:0] == CH))) begin
         emit            = 1'b1;
         ev_new.on       = (rs[7:4] == NOTE_ON) && (in_data[6:0] != 7'd0);
         ev_new.note     = d1;
         ev_new.velocity = in_data[6:0];
         ev_new.channel  = rs[3:0];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= ST_IDLE;
         rs       <= '0;
         rs_valid <= 1'b0;
         d1       <= '0;
      end else if (in_valid && !is_rt) begin
         if (is_status) begin
            if (in_data < SYSEX) begin
               rs       <= in_data;
               rs_valid <= 1'b1;
               state    <= ST_D1;
            end else begin
               rs_valid <= 1'b0;
               state    <= (in_data == SYSEX) ? ST_SKIP : ST_IDLE;
            end
         end else begin
            unique case (state)
               ST_D1: begin
                  d1    <= in_data[6:0];
                  state <= is_one_data(rs[7:4]) ? ST_D1 : ST_D2;
               end
               ST_D2:   state <= ST_D1;
               default: ;
            endcase
         end
      end
   end

   assign drop = emit && fifo_full && !(ev_valid && ev_ready);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)           overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
   end

   midi_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .nreset (nreset),
      .push   (emit),
      .wdata  (ev_new),
      .pop    (ev_ready),
      .rdata  (head),
      .empty  (fifo_empty),
      .full   (fifo_full)
   );

   assign ev_valid    = !fifo_empty;
   assign ev_on       = head.on;
   assign ev_note     = head.note;
   assign ev_velocity = head.velocity;
   assign ev_channel  = head.channel;

endmodule

// File: tb/tb_midi_event_parser.sv
// Scoreboard bench: an omni instance (a) and a channel-2 instance (b).
module tb_midi_event_parser;
   import midi_pkg::*;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;

   logic       in_valid_a = 1'b0, in_valid_b = 1'b0;
   logic [7:0] in_data_a = '0, in_data_b = '0;
   logic       ev_ready_a = 1'b1, ev_ready_b = 1'b1;
   logic       overflow_clr_a = 1'b0, overflow_clr_b = 1'b0;
   logic       ev_valid_a, ev_valid_b;
   logic       ev_on_a, ev_on_b;
   logic [6:0] ev_note_a, ev_note_b, ev_velocity_a, ev_velocity_b;
   logic [3:0] ev_channel_a, ev_channel_b;
   logic       overflow_a, overflow_b;

   int checks = 0;
   int failures = 0;
   int got_a = 0;
   int got_b = 0;
   midi_event_t exp_a[$];
   midi_event_t exp_b[$];

   always #5 clk = ~clk;

   midi_event_parser #(.CHANNEL(0), .OMNI(1'b1), .FIFO_DEPTH(4)) u_dut_a (
      .clk(clk), .nreset(nreset), .in_valid(in_valid_a), .in_data(in_data_a),
      .ev_valid(ev_valid_a), .ev_ready(ev_ready_a), .ev_on(ev_on_a),
      .ev_note(ev_note_a), .ev_velocity(ev_velocity_a), .ev_channel(ev_channel_a),
      .overflow(overflow_a), .overflow_clr(overflow_clr_a)
   );

   midi_event_parser #(.CHANNEL(2), .OMNI(1'b0), .FIFO_DEPTH(4)) u_dut_b (
      .clk(clk), .nreset(nreset), .in_valid(in_valid_b), .in_data(in_data_b),
      .ev_valid(ev_valid_b), .ev_ready(ev_ready_b), .ev_on(ev_on_b),
      .ev_note(ev_note_b), .ev_velocity(ev_velocity_b), .ev_channel(ev_channel_b),
      .overflow(overflow_b), .overflow_clr(overflow_clr_b)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic midi_event_t mk(input logic on, input logic [6:0] note,
                                      input logic [6:0] vel, input logic [3:0] ch);
      midi_event_t e;
      e.on = on; e.note = note; e.velocity = vel; e.channel = ch;
      return e;
   endfunction

   // Monitor: pops the scoreboard whenever a handshake is about to occur.
   always @(negedge clk) begin
      midi_event_t e;
      if (nreset && ev_valid_a && ev_ready_a) begin
         got_a++;
         if (exp_a.size() == 0) begin
            check("unexpected_event_a", {13'd0, ev_on_a, ev_note_a, ev_velocity_a, ev_channel_a}, 32'hFFFF_FFFF);
         end else begin
            e = exp_a.pop_front();
            check("event_a", {13'd0, ev_on_a, ev_note_a, ev_velocity_a, ev_channel_a}, 32'(e));
         end
      end
      if (nreset && ev_valid_b && ev_ready_b) begin
         got_b++;
         if (exp_b.size() == 0) begin
            check("unexpected_event_b", {13'd0, ev_on_b, ev_note_b, ev_velocity_b, ev_channel_b}, 32'hFFFF_FFFF);
         end else begin
            e = exp_b.pop_front();
            check("event_b", {13'd0, ev_on_b, ev_note_b, ev_velocity_b, ev_channel_b}, 32'(e));
         end
      end
   end

   task automatic send_a(input logic [7:0] b);
      in_valid_a = 1'b1; in_data_a = b;
      @(posedge clk); #1;
      in_valid_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] b);
      in_valid_b = 1'b1; in_data_b = b;
      @(posedge clk); #1;
      in_valid_b = 1'b0;
   endtask

   task automatic stream_a(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_a(bytes[i]);
   endtask

   task automatic stream_b(input logic [7:0] bytes[$]);
      foreach (bytes[i]) send_b(bytes[i]);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) begin @(posedge clk); #1; end
      check({name, "_drain_a"}, exp_a.size(), 0);
      check({name, "_drain_b"}, exp_b.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_a;
      int base_b;

      // Reset state
      #12;
      check("rst_ev_valid", ev_valid_a, 0);
      check("rst_outputs", {ev_on_a, ev_note_a, ev_velocity_a, ev_channel_a, overflow_a}, 0);
      @(posedge clk); #1;
      nreset = 1'b1;
      @(posedge clk); #1;

      // Basic note on with latency check
      exp_a.push_back(mk(1'b1, 7'h3C, 7'h64, 4'd0));
      send_a(8'h90);
      send_a(8'h3C);
      check("basic_not_early", ev_valid_a, 0);
      send_a(8'h64);
      check("basic_latency", ev_valid_a, 1);
      wait_drain("basic");

      // Running status and both note-off forms
      exp_a.push_back(mk(1'b1, 7'h3C, 7'h64, 4'd0));
      exp_a.push_back(mk(1'b1, 7'h40, 7'h50, 4'd0));
      exp_a.push_back(mk(1'b0, 7'h3C, 7'h00, 4'd0));
      exp_a.push_back(mk(1'b0, 7'h3C, 7'h40, 4'd0));
      stream_a('{8'h90, 8'h3C, 8'h64, 8'h40, 8'h50, 8'h3C, 8'h00, 8'h80, 8'h3C, 8'h40});
      wait_drain("running");

      // Real-time bytes interleaved
      exp_a.push_back(mk(1'b1, 7'h3C, 7'h64, 4'd0));
      stream_a('{8'h90, 8'hF8, 8'h3C, 8'hFE, 8'h64});
      wait_drain("realtime");

      // SysEx skip, then data after EOX with no running status
      base_a = got_a;
      stream_a('{8'hF0, 8'h01, 8'h3C, 8'h64, 8'hF7, 8'h3C, 8'h64});
      wait_drain("sysex");
      check("sysex_no_events", got_a - base_a, 0);

      // Channel filter on instance b
      base_b = got_b;
      exp_b.push_back(mk(1'b1, 7'h3C, 7'h64, 4'd2));
      stream_b('{8'h91, 8'h3C, 8'h64, 8'hC2, 8'h05, 8'h92, 8'h3C, 8'h64});
      wait_drain("chan");
      check("chan_event_count", got_b - base_b, 1);

      // Overflow, then full-with-pop acceptance, then drain and clear
      base_a = got_a;
      ev_ready_a = 1'b0;
      for (int n = 1; n <= 4; n++) exp_a.push_back(mk(1'b1, 7'(n), 7'h40, 4'd0));
      stream_a('{8'h90, 8'h01, 8'h40, 8'h02, 8'h40, 8'h03, 8'h40, 8'h04, 8'h40});
      check("full_valid", ev_valid_a, 1);
      check("full_head_note", ev_note_a, 7'h01);
      check("full_no_overflow", overflow_a, 0);
      send_a(8'h05);
      send_a(8'h40);
      check("overflow_set", overflow_a, 1);
      exp_a.push_back(mk(1'b1, 7'h06, 7'h40, 4'd0));
      send_a(8'h06);
      ev_ready_a = 1'b1;
      send_a(8'h40);
      check("full_pop_push_no_drop", got_a - base_a, 1);
      wait_drain("overflow");
      check("overflow_event_count", got_a - base_a, 5);
      check("overflow_sticky", overflow_a, 1);
      overflow_clr_a = 1'b1;
      @(posedge clk); #1;
      overflow_clr_a = 1'b0;
      check("overflow_cleared", overflow_a, 0);

      // Reset mid-message (head still holds note 6 before reset)
      base_a = got_a;
      send_a(8'h90);
      send_a(8'h3C);
      nreset = 1'b0;
      #2;
      check("midrst_valid", ev_valid_a, 0);
      check("midrst_outputs", {ev_on_a, ev_note_a, ev_velocity_a, ev_channel_a, overflow_a}, 0);
      @(posedge clk); #1;
      nreset = 1'b1;
      @(posedge clk); #1;
      send_a(8'h64);
      repeat (4) begin @(posedge clk); #1; end
      check("midrst_no_event", got_a - base_a, 0);
      check("midrst_valid_after", ev_valid_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/midi_event_parser.md
# midi_event_parser

Converts the raw MIDI byte stream delivered by the SPI slave into discrete note events for the voice allocator. It sits between the SPI slave's streaming source and the DDS voice/envelope logic, replacing ad-hoc byte counting with a status-aware parser. The parser handles running status, real-time bytes, SysEx skipping and note-on with velocity 0, and buffers events in a small FIFO with a valid/ready output.

## Interface
Parameters:
- CHANNEL, 0: MIDI channel (0-15) accepted when OMNI=0.
- OMNI, 1: 1 accepts note messages on all channels; 0 accepts only CHANNEL.
- FIFO_DEPTH, 4: event FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock; one clock domain.
- nreset  in  1  asynchronous, active-low reset.
- in_valid  in  1  one-cycle strobe per received byte.
- in_data  in  8  received byte; valid only when in_valid=1.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer takes the head event when ev_valid=1 and ev_ready=1.
- ev_on  out  1  1 = note on, 0 = note off.
- ev_note  out  7  MIDI note number.
- ev_velocity  out  7  velocity; 0 for note-on-velocity-0.
- ev_channel  out  4  source channel.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- overflow_clr  in  1  clears overflow.

## Operation
- Byte classes:
  - Status bytes have bit7=1; data bytes have bit7=0.
  - 0x80-0xEF are channel voice messages. They load the running-status register (rs, rs_valid=1) and go to D1.
  - 0xF0 goes to SKIP and clears rs_valid.
  - 0xF1-0xF7 clear rs_valid and go to IDLE. 0xF7 also ends SKIP.
  - 0xF8-0xFF (real-time) are ignored completely: no state, rs or data change, at any point, including inside SKIP.
- States:
  - IDLE: data bytes are discarded.
  - D1: a data byte is latched as d1. For rs high nibble 0xC or 0xD (one-data-byte messages), the message completes here, nothing is emitted, and the state stays D1. Otherwise the state goes to D2.
  - D2: a data byte is latched as d2 and the message completes. The state returns to D1, keeping running status.
  - SKIP: data bytes are discarded. Any non-real-time status byte exits SKIP and is processed normally.
- A status byte received in D1 or D2 abandons the partial message.
- Emission happens on completion in D2, only when rs high nibble is 0x8 or 0x9 and the channel matches (OMNI, or rs[3:0]==CHANNEL):
  - 0x9n with d2≠0 gives ev_on=1, velocity d2.
  - 0x9n with d2=0 gives ev_on=0, velocity 0.
  - 0x8n gives ev_on=0, velocity d2.
  - All other messages are parsed and discarded.
- FIFO (show-ahead): the ev_* outputs always reflect the head entry. Push on emit; pop on ev_valid&&ev_ready.
  - Full and no pop: the event is dropped and overflow is set.
  - Full with a simultaneous pop: the push is accepted.
  - Empty: the head outputs hold their last value and must not be used.
- overflow: a set and overflow_clr in the same cycle leaves overflow=1.

## Timing
- Reset (asynchronous, active-low):
  - State=IDLE, rs_valid=0, FIFO empty.
  - ev_valid=0, ev_on=0, ev_note=0, ev_velocity=0, ev_channel=0, overflow=0.
  - Asserting reset mid-message discards the partial message.
- Latency: the event appears on ev_valid in the cycle after the in_valid of its final data byte.
- Throughput: one byte per cycle and one pop per cycle.
- Back-to-back in_valid on consecutive cycles must be handled.
- ev_* outputs are registered or FIFO-RAM outputs; there is no combinational path from in_* to ev_*.

## Structure
- Package midi_pkg holds:
  - Status nibble constants: NOTE_OFF=4'h8, NOTE_ON=4'h9, PROG=4'hC, CHPRESS=4'hD.
  - Byte constants: SYSEX=8'hF0, EOX=8'hF7, RT_MIN=8'hF8.
  - Parser state enum.
  - midi_event_t typedef {on, note[6:0], velocity[6:0], channel[3:0]}, 19 bits.
- Sub-module: midi_event_fifo, a synchronous show-ahead FIFO of midi_event_t with FIFO_DEPTH entries and full/empty flags.
- The parser FSM and running status live in midi_event_parser.

## Test plan
- Basic note on: 90 3C 64 with ev_ready=1 -> one event {on=1, note=0x3C, vel=0x64, ch=0}; ev_valid is high the cycle after the 0x64 strobe.
- Running status and off forms: 90 3C 64 40 50 3C 00, then 80 3C 40 -> events on/3C/64, on/40/50, off/3C/00, off/3C/40, in order.
- Real-time interleave and SysEx:
  - 90 F8 3C FE 64 -> exactly one event, identical to the basic note-on case.
  - F0 01 3C 64 F7 3C 64 -> no events.
- Channel filter: with OMNI=0, CHANNEL=2, the stream 91 3C 64, then C2 05, then 92 3C 64 -> only one event {ch=2}; the program change emits nothing.
- Overflow: FIFO_DEPTH=4, ev_ready=0, five note-ons (notes 1-5) -> four held, overflow=1. Then ev_ready=1 drains notes 1-4 in order, and overflow_clr clears overflow.
- Reset mid-message: 90 3C, then pulse nreset low, then 64 -> no event, all outputs 0 during reset.
